// File: rtl/dac_sample_stream_pkg.sv
// Shared types for the DAC sample stream.
// Playback state encoding and silence level.
package dac_sample_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_e;

  localparam logic [7:0] DAC_MIDSCALE = 8'h80;

endpackage

// File: rtl/dac_sample_stream_fifo.sv
// Single-clock sample FIFO with explicit level counter.
// Inferred RAM with registered read; flush wins over push/pop.
module sample_fifo
  import dac_sample_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstn_async,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LVL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_rd) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (do_wr && !do_rd)
        level <= level + LW'(1);
      else if (do_rd && !do_wr)
        level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/dac_sample_stream.sv
// Elastic sample buffer and rate pacer feeding the PWM DAC.
// Primes, plays one sample per tick, tracks underruns.
module dac_sample_stream
  import dac_sample_stream_pkg::*;
#(
  parameter int         DEPTH_LOG2  = 6,
  parameter int         SAMPLE_DIV  = 2268,
  parameter int         PRIME_LEVEL = 32,
  parameter int         AFULL_LEVEL = 56,
  parameter logic [7:0] MIDSCALE    = DAC_MIDSCALE
) (
  input  logic                clk,
  input  logic                rstn_async,
  input  logic                enable,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [7:0]          dac_val,
  output logic                playing,
  output logic [DEPTH_LOG2:0] level,
  output logic                almost_full,
  output logic                overflow,
  output logic [7:0]          underrun_cnt
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            run;
  logic            tick;
  logic            live;
  logic            pop;
  logic            urun_evt;
  logic            prime_ok;
  logic            mid_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_rd_data;

  sample_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk        (clk),
    .rstn_async (rstn_async),
    .flush      (flush),
    .wr_en      (in_valid),
    .wr_data    (in_data),
    .rd_en      (pop),
    .rd_data    (fifo_rd_data),
    .level      (level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign run      = (state_q == ST_PLAY) || (state_q == ST_UNDERRUN);
  assign tick     = run && (cnt_q == CNT_MAX);
  assign live     = enable && !flush;
  assign pop      = live && (state_q == ST_PLAY) && tick && !fifo_empty;
  assign urun_evt = live && (state_q == ST_PLAY) && tick && fifo_empty;
  assign prime_ok = (level >= PRIME_L);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (enable) state_d = prime_ok ? ST_PLAY : ST_PRIME;
      ST_PRIME:    if (prime_ok) state_d = ST_PLAY;
      ST_PLAY:     if (tick && fifo_empty) state_d = ST_UNDERRUN;
      ST_UNDERRUN: if (prime_ok) state_d = ST_PLAY;
      default:     state_d = ST_IDLE;
    endcase
    if (flush) state_d = enable ? ST_PRIME : ST_IDLE;
    if (!enable) state_d = ST_IDLE;
  end

  // Pacer restarts from zero on every entry into PLAY.
  always_comb begin
    cnt_d = '0;
    if (run && !(state_d == ST_PLAY && state_q != ST_PLAY))
      cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mid_q        <= 1'b1;
      overflow     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!live) mid_q <= 1'b1;
      else if (pop) mid_q <= 1'b0;
      if (flush) overflow <= 1'b0;
      else if (in_valid && !in_ready) overflow <= 1'b1;
      if (urun_evt && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  // Registered FIFO head is shown unless silenced.
  assign dac_val     = mid_q ? MIDSCALE : fifo_rd_data;
  assign playing     = (state_q == ST_PLAY);
  assign in_ready    = !fifo_full;
  assign almost_full = (level >= AFULL_L);

endmodule

// File: tb/tb_dac_sample_stream.sv
// Directed self-checking bench for dac_sample_stream.
// Small SAMPLE_DIV keeps playback scenarios short.
module tb_dac_sample_stream;

  localparam int SD = 10;

  logic       clk;
  logic       rstn_async;
  logic       enable;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] dac_val;
  logic       playing;
  logic [6:0] level;
  logic       almost_full;
  logic       overflow;
  logic [7:0] underrun_cnt;

  int tests;
  int fails;

  dac_sample_stream #(
    .DEPTH_LOG2  (6),
    .SAMPLE_DIV  (SD),
    .PRIME_LEVEL (32),
    .AFULL_LEVEL (56),
    .MIDSCALE    (8'h80)
  ) dut (
    .clk          (clk),
    .rstn_async   (rstn_async),
    .enable       (enable),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .dac_val      (dac_val),
    .playing      (playing),
    .level        (level),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn_async = 1'b0;
    enable     = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    step();
    step();
    rstn_async = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 8'h10);
      step();
    end
    tests++;
    if (level !== 7'd5) begin
      fails++;
      $display("FAIL pre_reset_level: got %0d want 5", level);
    end
    #2;
    rstn_async = 1'b0;
    #1;
    tests++;
    if (level !== 7'd0) begin
      fails++;
      $display("FAIL rst_level: got %0d want 0", level);
    end
    tests++;
    if (dac_val !== 8'h80) begin
      fails++;
      $display("FAIL rst_dac: got %0h want 80", dac_val);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_ready: got %0b want 1", in_ready);
    end
    tests++;
    if (playing !== 1'b0) begin
      fails++;
      $display("FAIL rst_playing: got %0b want 0", playing);
    end
    tests++;
    if (almost_full !== 1'b0) begin
      fails++;
      $display("FAIL rst_afull: got %0b want 0", almost_full);
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL rst_overflow: got %0b want 0", overflow);
    end
    tests++;
    if (underrun_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rst_underrun: got %0d want 0", underrun_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_prime();
    int n;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 31; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (playing !== 1'b0 || level !== 7'd31) begin
      fails++;
      $display("FAIL prime_31: playing %0b level %0d want 0/31",
               playing, level);
    end
    in_valid = 1'b1;
    in_data  = 8'd31;
    step();
    in_valid = 1'b0;
    tests++;
    if (playing !== 1'b0 || level !== 7'd32) begin
      fails++;
      $display("FAIL prime_32_same: playing %0b level %0d want 0/32",
               playing, level);
    end
    step();
    tests++;
    if (playing !== 1'b1 || dac_val !== 8'h80) begin
      fails++;
      $display("FAIL prime_play: playing %0b dac %0h want 1/80",
               playing, dac_val);
    end
    n = 1;
    while (dac_val === 8'h80 && n < 100) begin
      step();
      n++;
    end
    tests++;
    if (n != SD + 1) begin
      fails++;
      $display("FAIL prime_latency: got %0d cycles want %0d", n, SD + 1);
    end
    tests++;
    if (dac_val !== 8'h00 || level !== 7'd31) begin
      fails++;
      $display("FAIL prime_first: dac %0h level %0d want 00/31",
               dac_val, level);
    end
  endtask

  task automatic test_order_rate();
    do_reset();
    enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          in_valid = 1'b1;
          in_data  = 8'(i);
          step();
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        logic [7:0] prev;
        n = 0;
        while (dac_val === 8'h80 && n < 200) begin
          step();
          n++;
        end
        tests++;
        if (dac_val !== 8'h00) begin
          fails++;
          $display("FAIL order_first: got %0h want 00", dac_val);
        end
        for (int i = 1; i < 64; i++) begin
          prev = dac_val;
          n = 0;
          while (dac_val === prev && n < 3 * SD) begin
            step();
            n++;
          end
          tests++;
          if (dac_val !== 8'(i) || n != SD) begin
            fails++;
            $display("FAIL order_step%0d: dac %0h after %0d want %0h after %0d",
                     i, dac_val, n, 8'(i), SD);
          end
        end
      end
    join
  endtask

  task automatic test_underrun();
    int n;
    for (int i = 0; i < SD - 1; i++) step();
    tests++;
    if (underrun_cnt !== 8'd0 || playing !== 1'b1) begin
      fails++;
      $display("FAIL urun_before: cnt %0d playing %0b want 0/1",
               underrun_cnt, playing);
    end
    step();
    tests++;
    if (underrun_cnt !== 8'd1 || playing !== 1'b0 || dac_val !== 8'h3F) begin
      fails++;
      $display("FAIL urun_hit: cnt %0d playing %0b dac %0h want 1/0/3f",
               underrun_cnt, playing, dac_val);
    end
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      step();
      if (i == 30) begin
        tests++;
        if (playing !== 1'b0 || dac_val !== 8'h3F) begin
          fails++;
          $display("FAIL urun_31: playing %0b dac %0h want 0/3f",
                   playing, dac_val);
        end
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (playing !== 1'b1) begin
      fails++;
      $display("FAIL urun_resume: playing %0b want 1", playing);
    end
    n = 1;
    while (dac_val === 8'h3F && n < 100) begin
      step();
      n++;
    end
    tests++;
    if (dac_val !== 8'h40 || n != SD + 1 || underrun_cnt !== 8'd1) begin
      fails++;
      $display("FAIL urun_refill: dac %0h n %0d cnt %0d want 40/%0d/1",
               dac_val, n, SD + 1, underrun_cnt);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      if (i == 54) begin
        tests++;
        if (almost_full !== 1'b0) begin
          fails++;
          $display("FAIL afull_55: got %0b want 0", almost_full);
        end
      end
      if (i == 55) begin
        tests++;
        if (almost_full !== 1'b1) begin
          fails++;
          $display("FAIL afull_56: got %0b want 1", almost_full);
        end
      end
    end
    in_data = 8'hEE;
    tests++;
    if (in_ready !== 1'b0 || level !== 7'd64 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_64: ready %0b level %0d ovf %0b want 0/64/0",
               in_ready, level, overflow);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if (overflow !== 1'b1 || level !== 7'd64) begin
      fails++;
      $display("FAIL full_65: ovf %0b level %0d want 1/64",
               overflow, level);
    end
  endtask

  task automatic test_disable_flush();
    int n;
    enable = 1'b1;
    step();
    tests++;
    if (playing !== 1'b1) begin
      fails++;
      $display("FAIL full_play: playing %0b want 1", playing);
    end
    n = 0;
    while (dac_val === 8'h80 && n < 100) begin
      step();
      n++;
    end
    tests++;
    if (dac_val !== 8'h00 || level !== 7'd63) begin
      fails++;
      $display("FAIL full_head: dac %0h level %0d want 00/63",
               dac_val, level);
    end
    enable = 1'b0;
    step();
    tests++;
    if (playing !== 1'b0 || dac_val !== 8'h80 || level !== 7'd63) begin
      fails++;
      $display("FAIL disable: playing %0b dac %0h level %0d want 0/80/63",
               playing, dac_val, level);
    end
    enable = 1'b1;
    step();
    tests++;
    if (playing !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL reenable: playing %0b ovf %0b want 1/1",
               playing, overflow);
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    tests++;
    if (level !== 7'd0 || overflow !== 1'b0 || dac_val !== 8'h80 ||
        playing !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush: level %0d ovf %0b dac %0h playing %0b ready %0b",
               level, overflow, dac_val, playing, in_ready);
    end
    step();
    tests++;
    if (level !== 7'd0 || playing !== 1'b0) begin
      fails++;
      $display("FAIL flush_after: level %0d playing %0b want 0/0",
               level, playing);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn_async = 1'b0;
    enable     = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    test_reset();
    test_prime();
    test_order_rate();
    test_underrun();
    test_full();
    test_disable_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
